// File: rtl/vertex_fetch_dma.sv
// Strided vertex-record DMA: issues in-order reads for count records and streams
// the returned {z,y,x} records through a credit-limited FIFO to the pipeline.
module vertex_fetch_dma #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] vertex_count,
  input  logic [15:0] stride_bytes,
  output logic        busy,
  output logic        done,
  output logic        rd_req_valid,
  input  logic        rd_req_ready,
  output logic [31:0] rd_addr,
  input  logic        rd_resp_valid,
  input  logic [95:0] rd_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] vertex_x,
  output logic [31:0] vertex_y,
  output logic [31:0] vertex_z
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state_q;
  logic [31:0]   count_q;
  logic [15:0]   stride_q;
  logic [31:0]   addr_q;
  logic [31:0]   issued_q;
  logic [31:0]   received_q;
  logic [31:0]   accepted_q;
  logic          zero_done_q;
  logic [95:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   fcnt_q;
  logic [AW:0]   fcnt_d;

  logic [31:0] outstanding;
  logic [31:0] occupancy;
  logic        req_valid;
  logic        req_fire;
  logic        push;
  logic        pop;
  logic        last_pop;

  // Credits count both in-flight reads and buffered records, so a push can never hit a full FIFO.
  assign outstanding = issued_q - received_q;
  assign occupancy   = outstanding + 32'(fcnt_q);
  assign req_valid   = (state_q == FETCH) && (issued_q < count_q)
                       && (occupancy < 32'(FIFO_DEPTH));
  assign req_fire    = req_valid && rd_req_ready;
  assign push        = rd_resp_valid && (outstanding != '0);
  assign pop         = (fcnt_q != '0) && out_ready;
  assign last_pop    = pop && (state_q == DRAIN) && (accepted_q + 32'd1 == count_q);

  assign rd_req_valid = req_valid;
  assign rd_addr      = addr_q;
  assign out_valid    = (fcnt_q != '0);
  assign vertex_x     = mem_q[rd_ptr_q][31:0];
  assign vertex_y     = mem_q[rd_ptr_q][63:32];
  assign vertex_z     = mem_q[rd_ptr_q][95:64];
  assign busy         = (state_q != IDLE);
  assign done         = zero_done_q || last_pop;

  always_comb begin
    fcnt_d = fcnt_q;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + (AW+1)'(1);
      2'b01:   fcnt_d = fcnt_q - (AW+1)'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      stride_q    <= '0;
      addr_q      <= '0;
      issued_q    <= '0;
      received_q  <= '0;
      accepted_q  <= '0;
      zero_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      zero_done_q <= 1'b0;
      fcnt_q      <= fcnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= rd_resp_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
        received_q      <= received_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        accepted_q <= accepted_q + 32'd1;
      end
      if (req_fire) begin
        issued_q <= issued_q + 32'd1;
        addr_q   <= addr_q + {16'h0, stride_q};
      end
      // Start handling comes last so its counter clears take priority.
      case (state_q)
        IDLE: begin
          if (start) begin
            if (vertex_count == '0) begin
              zero_done_q <= 1'b1;
            end else begin
              count_q    <= vertex_count;
              stride_q   <= stride_bytes;
              addr_q     <= base_addr;
              issued_q   <= '0;
              received_q <= '0;
              accepted_q <= '0;
              state_q    <= FETCH;
            end
          end
        end
        FETCH: if (req_fire && (issued_q + 32'd1 == count_q)) state_q <= DRAIN;
        DRAIN: if (last_pop) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_fetch_dma.sv
// Randomized bench for vertex_fetch_dma: an in-order memory model with variable
// latency feeds the DUT; frames are checked against address/data computed from base+i*stride.
module tb_vertex_fetch_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] vertex_count = '0;
  logic [15:0] stride_bytes = '0;
  logic        busy, done, rd_req_valid, out_valid;
  logic        rd_req_ready = 1'b0;
  logic [31:0] rd_addr;
  logic        rd_resp_valid = 1'b0;
  logic [95:0] rd_resp_data = '0;
  logic        out_ready = 1'b0;
  logic [31:0] vertex_x, vertex_y, vertex_z;

  always #5 clk = ~clk;

  vertex_fetch_dma #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .vertex_count(vertex_count), .stride_bytes(stride_bytes), .busy(busy), .done(done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .out_valid(out_valid),
    .out_ready(out_ready), .vertex_x(vertex_x), .vertex_y(vertex_y), .vertex_z(vertex_z)
  );

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int          cyc = 0;
  int unsigned req_pct = 100, out_pct = 100, lat_min = 1, lat_max = 1;
  logic [31:0] salt = 32'h0;
  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  logic [95:0] out_q[$];
  int          pend_due[$];
  logic [95:0] pend_data[$];
  int          last_due = 0;
  int          done_cnt, done_cyc, busy_seen, stall_err, max_inflight;
  int          first_out_cyc, last_out_cyc, start_cyc;
  logic        busy_at_done;
  logic        prev_stall = 1'b0;
  logic [95:0] prev_vtx = '0;

  function automatic logic [31:0] exp_addr(input logic [31:0] b, input logic [15:0] s,
                                           input int unsigned i);
    return b + i * {16'h0, s};
  endfunction

  function automatic logic [95:0] vdata(input logic [31:0] a, input logic [31:0] k);
    return {a ^ k, (a * 32'd7) + k, ~a + k};
  endfunction

  // One clock: sample the current cycle at negedge, then drive next-cycle inputs after posedge.
  task automatic step();
    int          due;
    logic [95:0] vtx;
    @(negedge clk);
    cyc++;
    vtx = {vertex_z, vertex_y, vertex_x};
    if (busy === 1'b1) busy_seen++;
    if (prev_stall && (out_valid !== 1'b1 || vtx !== prev_vtx)) stall_err++;
    prev_stall = (out_valid === 1'b1) && !out_ready && !reset;
    prev_vtx   = vtx;
    if (!reset && rd_req_valid === 1'b1 && rd_req_ready) begin
      req_addr_q.push_back(rd_addr);
      req_cyc_q.push_back(cyc);
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_due.push_back(due);
      pend_data.push_back(vdata(rd_addr, salt));
    end
    if (!reset && out_valid === 1'b1 && out_ready) begin
      out_q.push_back(vtx);
      if (out_q.size() == 1) first_out_cyc = cyc;
      last_out_cyc = cyc;
    end
    if (!reset && done === 1'b1) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    if (int'(req_addr_q.size()) - int'(out_q.size()) > max_inflight)
      max_inflight = int'(req_addr_q.size()) - int'(out_q.size());
    @(posedge clk);
    #1;
    rd_resp_valid = 1'b0;
    rd_resp_data  = '0;
    if (pend_due.size() != 0 && pend_due[0] == cyc + 1) begin
      rd_resp_valid = 1'b1;
      rd_resp_data  = pend_data.pop_front();
      void'(pend_due.pop_front());
    end
    rd_req_ready = ($urandom_range(99) < req_pct);
    out_ready    = ($urandom_range(99) < out_pct);
  endtask

  task automatic start_frame(input logic [31:0] b, input logic [31:0] c, input logic [15:0] s);
    req_addr_q.delete(); req_cyc_q.delete(); out_q.delete();
    done_cnt = 0; busy_seen = 0; stall_err = 0; max_inflight = 0;
    done_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    start = 1'b1; base_addr = b; vertex_count = c; stride_bytes = s;
    step();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    for (int i = 0; i < budget && done_cnt == 0; i++) step();
    ok = (done_cnt != 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (rd_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got=%b exp=0", rd_req_valid); end
    n_cmp++; if (rd_addr !== 32'h0) begin n_fail++; $display("FAIL reset_rd_addr got=%h exp=0", rd_addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if ({vertex_z, vertex_y, vertex_x} !== 96'h0) begin n_fail++; $display("FAIL reset_vertex got=%h exp=0", {vertex_z, vertex_y, vertex_x}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_fetch();
    bit ok;
    logic [31:0] exp_a [3];
    exp_a[0] = 32'h1000; exp_a[1] = 32'h100C; exp_a[2] = 32'h1018;
    req_pct = 100; out_pct = 100; lat_min = 1; lat_max = 1; salt = $urandom;
    start_frame(32'h1000, 32'd3, 16'd12);
    wait_done(60, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_done_timeout got=0 exp=1"); end
    n_cmp++; if (req_addr_q.size() != 3) begin n_fail++; $display("FAIL basic_req_count got=%0d exp=3", req_addr_q.size()); end
    for (int i = 0; i < 3 && i < req_addr_q.size(); i++) begin
      n_cmp++; if (req_addr_q[i] !== exp_a[i]) begin n_fail++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, req_addr_q[i], exp_a[i]); end
    end
    n_cmp++; if (out_q.size() != 3) begin n_fail++; $display("FAIL basic_out_count got=%0d exp=3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== vdata(exp_a[i], salt)) begin n_fail++; $display("FAIL basic_vertex[%0d] got=%h exp=%h", i, out_q[i], vdata(exp_a[i], salt)); end
    end
    n_cmp++; if (req_cyc_q.size() == 0 || req_cyc_q[0] != start_cyc + 1) begin n_fail++; $display("FAIL basic_first_req_latency got=%0d exp=%0d", req_cyc_q.size() ? req_cyc_q[0] : -1, start_cyc + 1); end
    // request N+1, response N+2, registered FIFO shows it at N+3
    n_cmp++; if (first_out_cyc != start_cyc + 3) begin n_fail++; $display("FAIL basic_first_out_latency got=%0d exp=%0d", first_out_cyc, start_cyc + 3); end
    n_cmp++; if (done_cyc != last_out_cyc) begin n_fail++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc, last_out_cyc); end
    n_cmp++; if (busy_at_done !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_done got=%b exp=1", busy_at_done); end
    step(); step();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] b;
    logic [15:0] s;
    b = $urandom; s = 16'($urandom_range(65535, 1)); salt = $urandom;
    req_pct = 100; out_pct = 0; lat_min = 1; lat_max = 1;
    out_ready = 1'b0;
    start_frame(b, 32'd10, s);
    for (int i = 0; i < 20; i++) step();
    n_cmp++; if (req_addr_q.size() != 4) begin n_fail++; $display("FAIL bp_credit_reqs got=%0d exp=4", req_addr_q.size()); end
    n_cmp++; if (rd_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid_stalled got=%b exp=0", rd_req_valid); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_stalled got=%b exp=1", out_valid); end
    out_pct = 100;
    wait_done(200, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_done_timeout got=0 exp=1"); end
    n_cmp++; if (out_q.size() != 10) begin n_fail++; $display("FAIL bp_out_count got=%0d exp=10", out_q.size()); end
    for (int unsigned i = 0; i < 10 && i < out_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== vdata(exp_addr(b, s, i), salt)) begin n_fail++; $display("FAIL bp_vertex[%0d] got=%h exp=%h", i, out_q[i], vdata(exp_addr(b, s, i), salt)); end
    end
    n_cmp++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_err); end
    n_cmp++; if (max_inflight > 4) begin n_fail++; $display("FAIL bp_inflight got=%0d exp<=4", max_inflight); end
  endtask

  task automatic test_zero_count();
    req_pct = 100; out_pct = 100;
    start_frame($urandom, 32'd0, 16'd4);
    step();
    n_cmp++; if (done_cyc != start_cyc + 1) begin n_fail++; $display("FAIL zero_done_cycle got=%0d exp=%0d", done_cyc, start_cyc + 1); end
    for (int i = 0; i < 6; i++) step();
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_pulses got=%0d exp=1", done_cnt); end
    n_cmp++; if (busy_seen != 0) begin n_fail++; $display("FAIL zero_busy_cycles got=%0d exp=0", busy_seen); end
    n_cmp++; if (req_addr_q.size() != 0) begin n_fail++; $display("FAIL zero_reqs got=%0d exp=0", req_addr_q.size()); end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF0; exp_a[1] = 32'h0000_0000; exp_a[2] = 32'h0000_0010;
    req_pct = 70; out_pct = 80; lat_min = 1; lat_max = 3; salt = $urandom;
    start_frame(32'hFFFF_FFF0, 32'd3, 16'd16);
    wait_done(200, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_done_timeout got=0 exp=1"); end
    n_cmp++; if (req_addr_q.size() != 3) begin n_fail++; $display("FAIL wrap_req_count got=%0d exp=3", req_addr_q.size()); end
    for (int i = 0; i < 3 && i < req_addr_q.size(); i++) begin
      n_cmp++; if (req_addr_q[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, req_addr_q[i], exp_a[i]); end
    end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== vdata(exp_a[i], salt)) begin n_fail++; $display("FAIL wrap_vertex[%0d] got=%h exp=%h", i, out_q[i], vdata(exp_a[i], salt)); end
    end
  endtask

  // Frames run back to back: each start lands in the cycle right after the previous done.
  task automatic test_random_back_to_back();
    bit ok;
    logic [31:0] b, c;
    logic [15:0] s;
    req_pct = 60; out_pct = 50; lat_min = 1; lat_max = 5;
    for (int f = 0; f < 5; f++) begin
      b = $urandom; c = $urandom_range(20, 5); s = 16'($urandom); salt = $urandom;
      start_frame(b, c, s);
      step();
      start = 1'b1; base_addr = ~b; vertex_count = c + 32'd7; stride_bytes = s ^ 16'h00F0;
      step();
      start = 1'b0;
      wait_done(3000, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand%0d_done_timeout got=0 exp=1", f); end
      n_cmp++; if (req_addr_q.size() != c) begin n_fail++; $display("FAIL rand%0d_req_count got=%0d exp=%0d", f, req_addr_q.size(), c); end
      n_cmp++; if (out_q.size() != c) begin n_fail++; $display("FAIL rand%0d_out_count got=%0d exp=%0d", f, out_q.size(), c); end
      for (int unsigned i = 0; i < c && i < req_addr_q.size(); i++) begin
        n_cmp++; if (req_addr_q[i] !== exp_addr(b, s, i)) begin n_fail++; $display("FAIL rand%0d_addr[%0d] got=%h exp=%h", f, i, req_addr_q[i], exp_addr(b, s, i)); end
      end
      for (int unsigned i = 0; i < c && i < out_q.size(); i++) begin
        n_cmp++; if (out_q[i] !== vdata(exp_addr(b, s, i), salt)) begin n_fail++; $display("FAIL rand%0d_vertex[%0d] got=%h exp=%h", f, i, out_q[i], vdata(exp_addr(b, s, i), salt)); end
      end
      n_cmp++; if (max_inflight > 4) begin n_fail++; $display("FAIL rand%0d_inflight got=%0d exp<=4", f, max_inflight); end
      n_cmp++; if (stall_err != 0) begin n_fail++; $display("FAIL rand%0d_stall_stable got=%0d exp=0", f, stall_err); end
      n_cmp++; if (done_cyc != last_out_cyc) begin n_fail++; $display("FAIL rand%0d_done_cycle got=%0d exp=%0d", f, done_cyc, last_out_cyc); end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int ov_cnt, due;
    logic [31:0] b;
    req_pct = 100; out_pct = 100; lat_min = 3; lat_max = 3; salt = $urandom;
    start_frame($urandom, 32'd8, 16'd12);
    for (int i = 0; i < 200 && out_q.size() < 2; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    due = (cyc + 2 > last_due) ? cyc + 2 : last_due + 1;
    last_due = due;
    pend_due.push_back(due);
    pend_data.push_back(96'hDEAD_0000_BEEF_0000_CAFE_0000);
    step();
    n_cmp++; if ({busy, done, rd_req_valid, out_valid} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_flags got=%b exp=0000", {busy, done, rd_req_valid, out_valid}); end
    n_cmp++; if (rd_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rd_addr got=%h exp=0", rd_addr); end
    n_cmp++; if ({vertex_z, vertex_y, vertex_x} !== 96'h0) begin n_fail++; $display("FAIL rst_mid_vertex got=%h exp=0", {vertex_z, vertex_y, vertex_x}); end
    ov_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid === 1'b1 || busy === 1'b1) ov_cnt++;
    end
    n_cmp++; if (ov_cnt != 0) begin n_fail++; $display("FAIL rst_mid_stale_dropped got=%0d exp=0", ov_cnt); end
    b = $urandom; salt = $urandom;
    start_frame(b, 32'd1, 16'd8);
    wait_done(100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rst_mid_new_done_timeout got=0 exp=1"); end
    n_cmp++; if (req_addr_q.size() != 1 || req_addr_q[0] !== b) begin n_fail++; $display("FAIL rst_mid_new_req got=%0d reqs exp=1 at %h", req_addr_q.size(), b); end
    n_cmp++; if (out_q.size() != 1 || out_q[0] !== vdata(b, salt)) begin n_fail++; $display("FAIL rst_mid_new_vertex got=%0d outs exp=1 of %h", out_q.size(), vdata(b, salt)); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_zero_count();
    test_addr_wrap();
    test_random_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
